// File: rtl/cdc_4phase_src.sv
// Source end of a four-phase req/ack word crossing.
// Holds the word stable while req is up; ack comes back through a sync chain.
module cdc_4phase_src #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             busy_o,
  output logic             async_req_o,
  output logic [WIDTH-1:0] async_data_o,
  input  logic             async_ack_i
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_ACK_HI = 2'd1,
    WAIT_ACK_LO = 2'd2
  } state_t;

  generate
    if (STAGES < 2) begin : g_bad_stages
      $error("cdc_4phase_src: STAGES must be >= 2");
    end
  endgenerate

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STAGES-1:0]  r_ack_sync;
  logic               w_ack_s;
  logic               r_req;
  logic               w_req_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_data_nxt;
  logic               w_ready;

  assign w_ack_s = r_ack_sync[STAGES-1];

  // Ack synchronizer: raw async input lands directly on the first flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ack_sync <= '0;
    end else begin
      r_ack_sync <= {r_ack_sync[STAGES-2:0], async_ack_i};
    end
  end

  // State, request and data registers; reset wins over any transition.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= w_req_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Next-state: accept in IDLE, drop req on ack high, finish on ack low.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_data_nxt  = r_data;
    unique case (r_state)
      IDLE: begin
        if (valid_i) begin
          w_data_nxt  = data_i;
          w_req_nxt   = 1'b1;
          w_state_nxt = WAIT_ACK_HI;
        end
      end
      WAIT_ACK_HI: begin
        if (w_ack_s) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!w_ack_s) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Handshake outputs decode the state register only.
  assign w_ready      = (r_state == IDLE);
  assign ready_o      = w_ready;
  assign busy_o       = !w_ready;
  assign async_req_o  = r_req;
  assign async_data_o = r_data;

endmodule

// File: tb/tb_cdc_4phase_src.sv
// Directed bench for cdc_4phase_src, STAGES=2 and STAGES=3.
// Each instance gets an ack model that echoes req two clocks later.
module tb_cdc_4phase_src;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_a, valid_b;
  logic [31:0] din_a, din_b;
  logic        ready_a, ready_b;
  logic        busy_a, busy_b;
  logic        req_a, req_b;
  logic [31:0] dout_a, dout_b;
  logic        ack_a, ack_b;
  logic        d0_a, d0_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cdc_4phase_src #(.WIDTH(32), .STAGES(2)) u_a (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid_a), .ready_o(ready_a),
    .data_i(din_a), .busy_o(busy_a),
    .async_req_o(req_a), .async_data_o(dout_a),
    .async_ack_i(ack_a)
  );

  cdc_4phase_src #(.WIDTH(32), .STAGES(3)) u_b (
    .clk_i(clk), .rst_i(rst),
    .valid_i(valid_b), .ready_o(ready_b),
    .data_i(din_b), .busy_o(busy_b),
    .async_req_o(req_b), .async_data_o(dout_b),
    .async_ack_i(ack_b)
  );

  // Destination stand-in: ack after edge n equals req after edge n-2.
  always @(posedge clk) begin
    if (rst) begin
      d0_a <= 1'b0; ack_a <= 1'b0;
      d0_b <= 1'b0; ack_b <= 1'b0;
    end else begin
      d0_a <= req_a; ack_a <= d0_a;
      d0_b <= req_b; ack_b <= d0_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] words [3];
    int          acc_at [3];
    int          idx;
    int          rises;
    logic        prev_req;
    logic        pr;
    logic [31:0] exp_data;

    words[0] = 32'h1; words[1] = 32'h2; words[2] = 32'h3;

    // Reset held with valid and data asserted: nothing captured.
    rst = 1'b1;
    valid_a = 1'b1; valid_b = 1'b1;
    din_a = 32'hDEADBEEF; din_b = 32'hDEADBEEF;
    repeat (3) begin
      tick();
      check("rst_ready_a", ready_a, 1);
      check("rst_busy_a", busy_a, 0);
      check("rst_req_a", req_a, 0);
      check("rst_data_a", dout_a, 0);
      check("rst_ready_b", ready_b, 1);
      check("rst_req_b", req_b, 0);
      check("rst_data_b", dout_b, 0);
    end
    rst = 1'b0;
    valid_a = 1'b0; valid_b = 1'b0;
    tick();

    // Single transfer on both depths, accepted at edge 0.
    valid_a = 1'b1; valid_b = 1'b1;
    din_a = 32'hA5A5_0001; din_b = 32'hA5A5_0001;
    tick();
    valid_a = 1'b0; valid_b = 1'b0;
    check("acc_req_a", req_a, 1);
    check("acc_ready_a", ready_a, 0);
    check("acc_busy_a", busy_a, 1);
    check("acc_data_a", dout_a, 32'hA5A5_0001);
    check("acc_req_b", req_b, 1);
    check("acc_data_b", dout_b, 32'hA5A5_0001);
    for (int n = 1; n <= 12; n++) begin
      tick();
      check($sformatf("s2_req_e%0d", n), req_a, (n < 5) ? 1 : 0);
      check($sformatf("s2_rdy_e%0d", n), ready_a, (n >= 10) ? 1 : 0);
      check($sformatf("s2_dat_e%0d", n), dout_a, 32'hA5A5_0001);
      check($sformatf("s3_req_e%0d", n), req_b, (n < 6) ? 1 : 0);
      check($sformatf("s3_rdy_e%0d", n), ready_b, (n >= 12) ? 1 : 0);
    end

    // Back-to-back: valid held, words 1,2,3 accepted 11 cycles apart.
    exp_data = 32'hA5A5_0001;
    idx = 0; rises = 0; prev_req = 1'b0;
    acc_at[0] = -1; acc_at[1] = -1; acc_at[2] = -1;
    valid_a = 1'b1; din_a = words[0];
    for (int c = 0; c < 40; c++) begin
      pr = ready_a;
      tick();
      if (pr && valid_a && idx < 3) begin
        acc_at[idx] = c;
        exp_data = words[idx];
        idx++;
        if (idx == 3) valid_a = 1'b0;
        else din_a = words[idx];
      end
      check("b2b_data", dout_a, exp_data);
      if (req_a && !prev_req) rises++;
      prev_req = req_a;
    end
    check("b2b_count", idx, 3);
    check("b2b_pulses", rises, 3);
    check("b2b_acc0", acc_at[0], 0);
    check("b2b_acc1", acc_at[1], 11);
    check("b2b_acc2", acc_at[2], 22);

    // Valid pulsed while busy is ignored.
    valid_a = 1'b1; din_a = 32'h0000_00AA;
    tick();
    valid_a = 1'b0;
    tick(); tick();
    check("ign_busy", busy_a, 1);
    valid_a = 1'b1; din_a = 32'h0000_1234;
    tick();
    valid_a = 1'b0;
    check("ign_data", dout_a, 32'h0000_00AA);
    check("ign_ready", ready_a, 0);
    rises = 0; prev_req = req_a;
    for (int n = 4; n <= 12; n++) begin
      tick();
      if (req_a && !prev_req) rises++;
      prev_req = req_a;
    end
    check("ign_extra_req", rises, 0);
    check("ign_data_end", dout_a, 32'h0000_00AA);
    check("ign_ready_end", ready_a, 1);

    // Reset while waiting for ack high, then a clean transfer.
    valid_a = 1'b1; din_a = 32'h0000_0055;
    tick();
    valid_a = 1'b0;
    check("mr_req_pre", req_a, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_req", req_a, 0);
    check("mr_ready", ready_a, 1);
    check("mr_busy", busy_a, 0);
    check("mr_data", dout_a, 0);
    repeat (6) tick();
    valid_a = 1'b1; din_a = 32'h0000_0066;
    tick();
    valid_a = 1'b0;
    check("mr2_req", req_a, 1);
    check("mr2_data", dout_a, 32'h0000_0066);
    repeat (9) tick();
    check("mr2_ready_e9", ready_a, 0);
    tick();
    check("mr2_ready_e10", ready_a, 1);
    check("mr2_req_e10", req_a, 0);
    check("mr2_data_e10", dout_a, 32'h0000_0066);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
